// File: rtl/p_ffs_iter_if.sv
// Handshake bundle for the find-first-set iterator: vector in, one-hot/index beats out.
// Latency: none (wires only).
// Backpressure: o_rdy/i_rdy carry flow control on the input and output sides respectively.
interface p_ffs_iter_if #(
    parameter int W = 16
);
    localparam int IDX_W = $clog2(W);

    logic             i_vld;
    logic [W-1:0]     i_x;
    logic             o_rdy;
    logic             o_vld;
    logic [W-1:0]     o_onehot;
    logic [IDX_W-1:0] o_idx;
    logic             o_last;
    logic             i_rdy;
    logic             o_busy;

    // Iterator side: consumes vectors, produces beats.
    modport slave (
        input  i_vld, i_x, i_rdy,
        output o_rdy, o_vld, o_onehot, o_idx, o_last, o_busy
    );

    // Environment side: produces vectors, consumes beats.
    modport master (
        output i_vld, i_x, i_rdy,
        input  o_rdy, o_vld, o_onehot, o_idx, o_last, o_busy
    );
endinterface

// File: rtl/p_ffs_iter.sv
// Drains a W-bit vector one set bit per beat, lowest bit first (one-hot + index + last).
// Latency: first beat one cycle after accept; k set bits take k beats with i_rdy held high.
// Backpressure: beat held stable while i_rdy low; new vector accepted on the last beat's handshake.
module p_ffs_iter #(
    parameter int W = 16
) (
    input  logic          i_clk,
    input  logic          i_arst_n,
    p_ffs_iter_if.slave   bus
);
    localparam int IDX_W = $clog2(W);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ITER = 1'b1
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_res;
    logic             r_vld;
    logic             r_busy;
    logic [W-1:0]     r_onehot;
    logic [IDX_W-1:0] r_idx;
    logic             r_last;

    logic [W-1:0]     w_res_nxt;
    logic [W-1:0]     w_low;
    logic [W-1:0]     w_rest;
    logic [IDX_W-1:0] w_idx;
    logic             w_nonzero;
    logic             w_rdy;

    // Accept in IDLE, or when the final beat of the current vector is taken this cycle.
    assign w_rdy = (r_state == S_IDLE) || ((r_state == S_ITER) && r_last && bus.i_rdy);

    // Next residual: load a fresh vector, strip the bit just delivered, or hold under backpressure.
    always_comb begin
        w_res_nxt = r_res;
        case (r_state)
            S_IDLE: begin
                if (bus.i_vld) begin
                    w_res_nxt = bus.i_x;
                end
            end
            S_ITER: begin
                if (bus.i_rdy) begin
                    if (r_last) begin
                        w_res_nxt = bus.i_vld ? bus.i_x : '0;
                    end else begin
                        w_res_nxt = r_res & ~r_onehot;
                    end
                end
            end
            default: w_res_nxt = '0;
        endcase
    end

    // Precompute the next beat from the next residual so every output leaves a flop.
    assign w_low     = w_res_nxt & (~w_res_nxt + W'(1));
    assign w_rest    = w_res_nxt & ~w_low;
    assign w_nonzero = (w_res_nxt != '0);

    // Encode the isolated bit; at most one bit of w_low is set so OR-ing positions is exact.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (w_low[i]) begin
                w_idx = w_idx | IDX_W'(i);
            end
        end
    end

    // State machine with registered beat outputs; a zero vector leaves it in IDLE.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state  <= S_IDLE;
            r_res    <= '0;
            r_vld    <= 1'b0;
            r_busy   <= 1'b0;
            r_onehot <= '0;
            r_idx    <= '0;
            r_last   <= 1'b0;
        end else begin
            r_res    <= w_res_nxt;
            r_state  <= w_nonzero ? S_ITER : S_IDLE;
            r_vld    <= w_nonzero;
            r_busy   <= w_nonzero;
            r_onehot <= w_low;
            r_idx    <= w_idx;
            r_last   <= w_nonzero && (w_rest == '0);
        end
    end

    assign bus.o_rdy    = w_rdy;
    assign bus.o_vld    = r_vld;
    assign bus.o_busy   = r_busy;
    assign bus.o_onehot = r_onehot;
    assign bus.o_idx    = r_idx;
    assign bus.o_last   = r_last;

    a_onehot: assert property (@(posedge i_clk) disable iff (!i_arst_n)
        r_vld |-> $onehot(r_onehot));

    a_hold: assert property (@(posedge i_clk) disable iff (!i_arst_n)
        (r_vld && !bus.i_rdy) |=> $stable(r_onehot));
endmodule

// File: tb/tb_p_ffs_iter.sv
module tb_p_ffs_iter;
    localparam int W = 16;

    typedef struct {
        int idx;
        bit last;
    } beat_t;

    logic i_clk;
    logic i_arst_n;

    p_ffs_iter_if #(.W(W)) ifc ();

    p_ffs_iter #(.W(W)) dut (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .bus      (ifc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    beat_t q[$];
    int    n_vec;
    int    n_err;
    bit    acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beats of a vector: its set bit positions in ascending order.
    task automatic push_vec(input logic [W-1:0] x);
        int last_pos;
        last_pos = -1;
        for (int i = 0; i < W; i++) if (x[i]) last_pos = i;
        for (int i = 0; i < W; i++) begin
            if (x[i]) begin
                beat_t b;
                b.idx  = i;
                b.last = (i == last_pos);
                q.push_back(b);
            end
        end
    endtask

    // Check outputs mid-cycle, advance the model across the next rising edge.
    task automatic step();
        logic [W-1:0] e_oh;
        bit           e_vld, e_rdy;
        @(negedge i_clk);
        e_vld = (q.size() != 0);
        e_oh  = '0;
        if (e_vld) e_oh[q[0].idx] = 1'b1;
        e_rdy = !e_vld || (q[0].last && ifc.i_rdy);
        chk("o_vld",    64'(ifc.o_vld),    64'(e_vld));
        chk("o_busy",   64'(ifc.o_busy),   64'(e_vld));
        chk("o_rdy",    64'(ifc.o_rdy),    64'(e_rdy));
        chk("o_onehot", 64'(ifc.o_onehot), 64'(e_oh));
        chk("o_idx",    64'(ifc.o_idx),    e_vld ? 64'(q[0].idx) : 64'd0);
        chk("o_last",   64'(ifc.o_last),   e_vld ? 64'(q[0].last) : 64'd0);
        acc = ifc.i_vld && e_rdy && i_arst_n;
        if (e_vld && ifc.i_rdy && i_arst_n) void'(q.pop_front());
        if (acc) push_vec(ifc.i_x);
        @(posedge i_clk);
        #1;
    endtask

    // Present a vector until it is taken; an expired budget is a failure.
    task automatic send(input logic [W-1:0] x);
        int n;
        ifc.i_vld = 1'b1;
        ifc.i_x   = x;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            step();
            n++;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $error("FAIL send_timeout observed=%0d expected=accept", n);
        end
        ifc.i_vld = 1'b0;
        ifc.i_x   = $urandom;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        ifc.i_vld = 1'b0;
        ifc.i_x   = '0;
        ifc.i_rdy = 1'b1;
        i_arst_n  = 1'b0;
        #2;
        chk("rst_vld",    64'(ifc.o_vld),    64'd0);
        chk("rst_rdy",    64'(ifc.o_rdy),    64'd1);
        chk("rst_busy",   64'(ifc.o_busy),   64'd0);
        chk("rst_onehot", 64'(ifc.o_onehot), 64'd0);
        chk("rst_idx",    64'(ifc.o_idx),    64'd0);
        chk("rst_last",   64'(ifc.o_last),   64'd0);
        @(posedge i_clk);
        #1;
        i_arst_n = 1'b1;
        drain(2);

        // Sparse vector, four beats.
        send(16'h8421);
        drain(5);

        // Back-to-back vectors with no bubble.
        send(16'h0003);
        send(16'h8000);
        drain(3);

        // Backpressure on the first beat.
        send(16'h0110);
        ifc.i_rdy = 1'b0;
        drain(3);
        ifc.i_rdy = 1'b1;
        drain(3);

        // Zero vector is swallowed, next vector proceeds normally.
        send(16'h0000);
        drain(2);
        send(16'h0840);
        drain(3);

        // All ones.
        send(16'hFFFF);
        drain(18);

        // Lone top bit.
        send(16'h8000);
        drain(2);

        // Reset in the middle of a vector.
        send(16'h00FF);
        drain(2);
        i_arst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(ifc.o_vld), 64'd0);
        chk("arst_rdy", 64'(ifc.o_rdy), 64'd1);
        q.delete();
        drain(2);
        i_arst_n = 1'b1;
        drain(3);
        send(16'h0004);
        drain(3);

        // Randomised traffic with random downstream stalls.
        for (int i = 0; i < 600; i++) begin
            int sel;
            ifc.i_rdy = ($urandom_range(3) != 0);
            ifc.i_vld = ($urandom_range(1) != 0);
            sel = $urandom_range(7);
            if (sel == 0)      ifc.i_x = '0;
            else if (sel == 1) ifc.i_x = W'(1) << $urandom_range(W - 1);
            else               ifc.i_x = W'($urandom);
            step();
        end
        ifc.i_vld = 1'b0;
        ifc.i_rdy = 1'b1;
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/p_ffs_iter.md
Name: p_ffs_iter

Overview:
- Sequential counterpart to the combinational find-first-set primitive in the p_ library.
- Accepts a W-bit request vector and walks its set bits lowest-first, emitting one set bit per beat.
- Each beat carries a one-hot mask, a binary index and a last flag, under valid/ready handshakes on both sides.
- Used wherever a bulk vector (pending interrupts, free slots, dirty lines) must be drained one element at a time.

Parameters:
- W, 16, vector width; legal range 2..256.
- (derived localparam) IDX_W = $clog2(W), index width.

Ports:
- i_clk  input  1  clock.
- i_arst_n  input  1  asynchronous active-low reset.
- i_vld  input  1  input vector valid.
- i_x  input  W  input vector.
- o_rdy  output  1  block can accept a vector this cycle.
- o_vld  output  1  output beat valid.
- o_onehot  output  W  lowest remaining set bit, one-hot.
- o_idx  output  IDX_W  binary index of o_onehot.
- o_last  output  1  current beat is the final set bit of the vector.
- i_rdy  input  1  downstream accepts beat.
- o_busy  output  1  vector in progress (state ITER).

Behaviour:
- Single clock i_clk. Reset i_arst_n is asynchronous, active-low.
- Reset: state=IDLE, residual r=0.
  - Outputs during and after reset: o_vld=0, o_onehot=0, o_idx=0, o_last=0, o_busy=0, o_rdy=1.
- State machine:
  - IDLE: o_rdy=1, o_vld=0. On i_vld&&o_rdy:
    - If i_x!=0: r<=i_x, go to ITER.
    - If i_x==0: vector is consumed and discarded; no beat is emitted; remain in IDLE.
  - ITER: o_vld=1, o_busy=1.
    - o_onehot = r & (~r + 1).
    - o_idx = position of o_onehot.
    - o_last = ((r & ~o_onehot) == 0).
  - ITER, i_rdy=1 and o_last=0: r<=r & ~o_onehot; stay in ITER.
  - ITER, i_rdy=1 and o_last=1: beat completes.
    - If i_vld and i_x!=0 in the same cycle: r<=i_x, stay in ITER.
    - Otherwise: r<=0, go to IDLE.
- o_rdy is combinational: o_rdy = (state==IDLE) | (state==ITER & o_last & i_rdy). This gives back-to-back vectors with no bubble.
- Latency: a vector accepted in cycle N produces its first beat (o_vld=1) in cycle N+1. A vector with k set bits takes exactly k beats when i_rdy is held high.
- Outputs are driven from registered state only; there is no combinational path from i_x to o_vld, o_onehot, o_idx or o_last.
- Backpressure: while o_vld && !i_rdy, o_onehot, o_idx and o_last hold stable and r is unchanged.
- i_x is sampled only on the accept cycle (i_vld && o_rdy). i_x is ignored at all other times.
- o_onehot always has exactly one bit set when o_vld=1 and is 0 otherwise. Same for o_idx and o_last: both are 0 when o_vld=0.
- Bit W-1 alone: o_idx=W-1, o_last=1.
- Reset asserted mid-iteration:
  - Outputs return to reset values immediately (asynchronously).
  - The residual is discarded.
  - No beat is issued after deassertion until a new vector is accepted.
- Optional assertions (simulation only):
  - $onehot(o_onehot) when o_vld.
  - No change of o_onehot while o_vld && !i_rdy.

Test Plan:
- W=16, i_x=0x8421, i_rdy=1 -> four consecutive beats: onehot 0x0001/idx 0, 0x0020/idx 5, 0x0400/idx 10, 0x8000/idx 15. o_last only on the idx 15 beat; IDLE afterwards.
- Back-to-back: 0x0003 presented, then 0x8000 held on i_vld -> 0x8000 is accepted on the beat-2 (last) cycle. Beats idx 0, 1(last), 15(last) occur on three consecutive cycles with no o_vld gap.
- Backpressure: i_x=0x0110, i_rdy low for 3 cycles on the first beat -> idx 4 is held stable 4 cycles; idx 8 (last) follows one cycle after i_rdy rises. o_rdy=0 throughout.
- Zero vector: i_vld=1, i_x=0 -> o_rdy=1 on the accept cycle. o_vld stays 0 and state stays IDLE; the next nonzero vector is processed normally.
- All ones: i_x=0xFFFF, i_rdy=1 -> 16 beats with idx 0..15 in order. o_last=1 only at idx 15; o_onehot is 1<<idx on every beat.
- Reset mid-iteration: after the 2nd beat of 0x00FF, pulse i_arst_n low asynchronously -> o_vld=0 and o_rdy=1 immediately. No residual beats after release; a new 0x0004 yields a single beat idx 2 with o_last=1.
